midi_message_parser: RTL and testbench

- Consumes the serial MIDI byte stream from the UART byte receiver: a one-cycle valid strobe plus an 8-bit byte.
- Assembles channel-voice messages, honouring running status, SysEx and real-time interleaving.
- Emits one registered event per completed Note On/Off, Control Change or Pitch Bend message.
- Feeds the downstream voice allocator / note tracker.

---
 rtl/midi_pkg.sv | 66 ++++++
 rtl/midi_byte_classifier.sv | 16 +
 rtl/midi_message_parser.sv | 114 +++++++++++
 tb/tb_midi_message_parser.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared types, constants and helpers for the MIDI channel-voice message parser.
package midi_pkg;

    // Event type encodings presented on event_type
    typedef enum logic [1:0] {
        EV_NOTE_ON        = 2'd0,
        EV_NOTE_OFF       = 2'd1,
        EV_CONTROL_CHANGE = 2'd2,
        EV_PITCH_BEND     = 2'd3
    } evt_type_t;

    // Channel status nibbles (upper four bits of a channel status byte)
    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] POLY_AT  = 4'hA;
    localparam logic [3:0] CC       = 4'hB;
    localparam logic [3:0] PROG     = 4'hC;
    localparam logic [3:0] CHAN_AT  = 4'hD;
    localparam logic [3:0] BEND     = 4'hE;

    // System byte values
    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] SYSEX_END   = 8'hF7;
    localparam logic [7:0] RT_MIN      = 8'hF8;

    // Parser FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_D1 = 2'd1,
        ST_WAIT_D2 = 2'd2,
        ST_SYSEX   = 2'd3
    } state_t;

    // Result of mapping a completed two-byte message onto an output event
    typedef struct packed {
        logic      emit;
        evt_type_t etype;
    } evt_map_t;

    // Number of data bytes that follow a channel status nibble (0 for non-channel nibbles)
    function automatic logic [1:0] data_len_of(input logic [3:0] nib);
        logic [1:0] len;
        case (nib)
            NOTE_OFF, NOTE_ON, POLY_AT, CC, BEND: len = 2'd2;
            PROG, CHAN_AT:                        len = 2'd1;
            default:                              len = 2'd0;
        endcase
        return len;
    endfunction

    // Map a completed two-data-byte message to an event; poly aftertouch is consumed silently
    function automatic evt_map_t map_event(input logic [3:0] nib, input logic [6:0] d2);
        evt_map_t r;
        r.emit  = 1'b1;
        r.etype = EV_NOTE_ON;
        case (nib)
            NOTE_ON:  r.etype = (d2 != 7'd0) ? EV_NOTE_ON : EV_NOTE_OFF;
            NOTE_OFF: r.etype = EV_NOTE_OFF;
            CC:       r.etype = EV_CONTROL_CHANGE;
            BEND:     r.etype = EV_PITCH_BEND;
            default:  r.emit  = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/midi_byte_classifier.sv
// Combinational decode of one received MIDI byte into its class and data length.
module midi_byte_classifier
    import midi_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic       is_status_o,
    output logic       is_realtime_o,
    output logic [1:0] data_len_o
);

    assign is_status_o   = byte_i[7];
    assign is_realtime_o = (byte_i >= RT_MIN);
    // Only channel status bytes carry a data length; data and system bytes report 0
    assign data_len_o    = byte_i[7] ? data_len_of(byte_i[7:4]) : 2'd0;

endmodule

// File: rtl/midi_message_parser.sv
// MIDI byte-stream parser: assembles channel-voice messages with running status,
// skips SysEx and real-time bytes, and emits one registered event per completed
// Note On/Off, Control Change or Pitch Bend message.
module midi_message_parser
    import midi_pkg::*;
#(
    parameter bit         CHANNEL_FILTER_EN = 1'b0,
    parameter logic [3:0] CHANNEL           = 4'd0
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       event_valid,
    output logic [1:0] event_type,
    output logic [3:0] event_channel,
    output logic [6:0] event_data1,
    output logic [6:0] event_data2
);

    logic       is_status;
    logic       is_realtime;
    logic [1:0] data_len;

    midi_byte_classifier u_classifier (
        .byte_i        (byte_data),
        .is_status_o   (is_status),
        .is_realtime_o (is_realtime),
        .data_len_o    (data_len)
    );

    state_t     state_q;
    logic [3:0] status_q;      // running status nibble, 0 when cleared
    logic [3:0] chan_q;        // running status channel
    logic       two_byte_q;    // running status kind needs two data bytes
    logic [6:0] d1_q;          // first data byte of the message in progress

    logic       ev_valid_q;
    evt_type_t  ev_type_q;
    logic [3:0] ev_chan_q;
    logic [6:0] ev_d1_q;
    logic [6:0] ev_d2_q;

    evt_map_t   map_d;
    logic       chan_ok_d;

    // Classify the message being completed by the current data byte
    always_comb begin
        map_d     = map_event(status_q, byte_data[6:0]);
        chan_ok_d = !CHANNEL_FILTER_EN || (chan_q == CHANNEL);
    end

    // Parser FSM with registered event outputs; real-time bytes leave everything untouched
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            status_q   <= 4'd0;
            chan_q     <= 4'd0;
            two_byte_q <= 1'b0;
            d1_q       <= 7'd0;
            ev_valid_q <= 1'b0;
            ev_type_q  <= EV_NOTE_ON;
            ev_chan_q  <= 4'd0;
            ev_d1_q    <= 7'd0;
            ev_d2_q    <= 7'd0;
        end else begin
            ev_valid_q <= 1'b0;
            if (byte_valid && !is_realtime) begin
                if (is_status) begin
                    if (byte_data < SYSEX_START) begin
                        // New channel status replaces running status and drops any partial message
                        status_q   <= byte_data[7:4];
                        chan_q     <= byte_data[3:0];
                        two_byte_q <= (data_len == 2'd2);
                        state_q    <= ST_WAIT_D1;
                    end else begin
                        // System common bytes cancel running status; only 0xF0 opens a SysEx
                        status_q   <= 4'd0;
                        two_byte_q <= 1'b0;
                        state_q    <= (byte_data == SYSEX_START) ? ST_SYSEX : ST_IDLE;
                    end
                end else begin
                    case (state_q)
                        ST_WAIT_D1: begin
                            // One-data-byte kinds complete here and stay for running status
                            if (two_byte_q) begin
                                d1_q    <= byte_data[6:0];
                                state_q <= ST_WAIT_D2;
                            end
                        end
                        ST_WAIT_D2: begin
                            state_q <= ST_WAIT_D1;
                            if (map_d.emit && chan_ok_d) begin
                                ev_valid_q <= 1'b1;
                                ev_type_q  <= map_d.etype;
                                ev_chan_q  <= chan_q;
                                ev_d1_q    <= d1_q;
                                ev_d2_q    <= byte_data[6:0];
                            end
                        end
                        default: ;  // IDLE and SYSEX discard data bytes
                    endcase
                end
            end
        end
    end

    assign event_valid   = ev_valid_q;
    assign event_type    = ev_type_q;
    assign event_channel = ev_chan_q;
    assign event_data1   = ev_d1_q;
    assign event_data2   = ev_d2_q;

endmodule

// File: tb/tb_midi_message_parser.sv
// Directed bench for the MIDI message parser: an unfiltered instance and a
// channel-1-filtered instance share one byte stream; expected events are queued
// per instance with the cycle they must appear in and checked by monitors.
module tb_midi_message_parser;

    logic       clk;
    logic       rst;
    logic       byte_valid;
    logic [7:0] byte_data;

    logic       ev0_valid, ev1_valid;
    logic [1:0] ev0_type,  ev1_type;
    logic [3:0] ev0_chan,  ev1_chan;
    logic [6:0] ev0_d1,    ev1_d1;
    logic [6:0] ev0_d2,    ev1_d2;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        int cyc;
        int t;
        int ch;
        int d1;
        int d2;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    midi_message_parser #(.CHANNEL_FILTER_EN(1'b0), .CHANNEL(4'd0)) dut0 (
        .CLOCK_50      (clk),
        .RESET         (rst),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .event_valid   (ev0_valid),
        .event_type    (ev0_type),
        .event_channel (ev0_chan),
        .event_data1   (ev0_d1),
        .event_data2   (ev0_d2)
    );

    midi_message_parser #(.CHANNEL_FILTER_EN(1'b1), .CHANNEL(4'd1)) dut1 (
        .CLOCK_50      (clk),
        .RESET         (rst),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .event_valid   (ev1_valid),
        .event_type    (ev1_type),
        .event_channel (ev1_chan),
        .event_data1   (ev1_d1),
        .event_data2   (ev1_d2)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one byte for exactly one cycle; back-to-back calls give full-rate strobes
    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        $display("[TB] byte 0x%02h", b);
    endtask

    // Drive the final data byte of a message and queue the event it must produce
    task automatic send_ev(input logic [7:0] b, input int t, input int ch,
                           input int d1, input int d2, input bit to1);
        exp_t e;
        send(b);
        e.cyc = cyc;
        e.t   = t;
        e.ch  = ch;
        e.d1  = d1;
        e.d2  = d2;
        q0.push_back(e);
        if (to1) q1.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor for the unfiltered instance
    always @(negedge clk) begin
        if (ev0_valid === 1'b1) begin
            if (q0.size() == 0) begin
                check("dut0_unexpected_event", ev0_valid, 0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                $display("[TB] dut0 event type=%0d ch=%0d d1=%0d d2=%0d cyc=%0d",
                         ev0_type, ev0_chan, ev0_d1, ev0_d2, cyc);
                check("dut0_cycle", cyc,      e.cyc);
                check("dut0_type",  ev0_type, e.t);
                check("dut0_chan",  ev0_chan, e.ch);
                check("dut0_d1",    ev0_d1,   e.d1);
                check("dut0_d2",    ev0_d2,   e.d2);
            end
        end
    end

    // Monitor for the channel-1-filtered instance
    always @(negedge clk) begin
        if (ev1_valid === 1'b1) begin
            if (q1.size() == 0) begin
                check("dut1_unexpected_event", ev1_valid, 0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                $display("[TB] dut1 event type=%0d ch=%0d d1=%0d d2=%0d cyc=%0d",
                         ev1_type, ev1_chan, ev1_d1, ev1_d2, cyc);
                check("dut1_cycle", cyc,      e.cyc);
                check("dut1_type",  ev1_type, e.t);
                check("dut1_chan",  ev1_chan, e.ch);
                check("dut1_d1",    ev1_d1,   e.d1);
                check("dut1_d2",    ev1_d2,   e.d2);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", ev0_valid, 0);
        check("reset_type",  ev0_type,  0);
        check("reset_chan",  ev0_chan,  0);
        check("reset_d1",    ev0_d1,    0);
        check("reset_d2",    ev0_d2,    0);
        rst = 1'b0;
        idle(2);

        // Basic Note On
        send(8'h90); send(8'h3C); send_ev(8'h64, 0, 0, 60, 100, 1'b0);
        idle(2);

        // Running status with a velocity-0 Note On becoming Note Off
        send(8'h93); send(8'h40); send_ev(8'h7F, 0, 3, 64, 127, 1'b0);
        send(8'h41); send_ev(8'h00, 1, 3, 65, 0, 1'b0);
        idle(2);

        // Control Change with a real-time byte between the data bytes
        send(8'hB0); send(8'h07); send(8'hF8); send_ev(8'h50, 2, 0, 7, 80, 1'b0);
        idle(2);

        // SysEx then stray data in IDLE: no events, previous outputs held
        send(8'hF0); send(8'h7E); send(8'h01); send(8'hF7); send(8'h3C); send(8'h40);
        idle(2);
        check("hold_type", ev0_type, 2);
        check("hold_d1",   ev0_d1,   7);
        check("hold_d2",   ev0_d2,   80);

        // Pitch Bend: d1 = LSB, d2 = MSB
        send(8'hE2); send(8'h00); send_ev(8'h40, 3, 2, 0, 64, 1'b0);
        idle(2);

        // Partial Note On aborted by a new status byte
        send(8'h90); send(8'h3C); send(8'h80); send(8'h3C); send_ev(8'h00, 1, 0, 60, 0, 1'b0);
        idle(2);

        // Channel 1 Note Off with release velocity: passes the filter
        send(8'h81); send(8'h3C); send_ev(8'h40, 1, 1, 60, 64, 1'b1);
        idle(2);

        // Poly aftertouch and program change (running status) produce nothing
        send(8'hA0); send(8'h3C); send(8'h40);
        send(8'hC5); send(8'h10); send(8'h11); send(8'h12);
        idle(2);

        // Channel 1 Note On with real-time interleave, then 0xF7 outside SysEx
        send(8'h91); send(8'hFE); send(8'h3C); send_ev(8'h64, 0, 1, 60, 100, 1'b1);
        send(8'hF7); send(8'h3C); send(8'h64);
        idle(2);

        // Filtered instance must stay silent for a channel-0 Note On
        send(8'h90); send(8'h3C); send_ev(8'h64, 0, 0, 60, 100, 1'b0);
        idle(2);

        // Reset mid-message clears outputs and drops the partial message
        send(8'h95); send(8'h3C);
        rst = 1'b1;
        #2;
        check("midreset_valid", ev0_valid, 0);
        check("midreset_type",  ev0_type,  0);
        check("midreset_chan",  ev0_chan,  0);
        check("midreset_d1",    ev0_d1,    0);
        check("midreset_d2",    ev0_d2,    0);
        check("midreset_d1_f",  ev1_d1,    0);
        idle(1);
        rst = 1'b0;
        send(8'h64);
        idle(3);

        // Parser is healthy after reset
        send(8'h91); send(8'h30); send_ev(8'h20, 0, 1, 48, 32, 1'b1);
        idle(3);

        check("dut0_pending", q0.size(), 0);
        check("dut1_pending", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
